id_stage: RTL and testbench

- Instruction-decode stage of the 5-stage MIPS pipeline. It is the producer side of the ID/EX pipeline register and drives every one of that register's inputs, including its flush.
- Contains the 32x32 register file with write-before-read bypass, the main control decoder, sign extension, the load-use and branch hazard unit, and early beq resolution.
- Also keeps a saturating stall performance counter.

---
 rtl/id_stage.sv | 161 ++++++++++++++++
 tb/tb_id_stage.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/id_stage.sv
// MIPS instruction-decode stage: register file with write-back bypass, control
// decoder, sign extension, load-use/branch hazard unit, early beq resolution.
module id_stage #(
  parameter int COUNT_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [31:0]        instr_in,
  input  logic [31:0]        pc_plus4_in,
  input  logic               wb_reg_write,
  input  logic [4:0]         wb_write_reg,
  input  logic [31:0]        wb_write_data,
  input  logic               ex_mem_read,
  input  logic               ex_reg_write,
  input  logic [4:0]         ex_write_reg,
  input  logic               mem_reg_write,
  input  logic [4:0]         mem_write_reg,
  output logic               RegDst,
  output logic               ALUSrc,
  output logic               MemtoReg,
  output logic               RegWrite,
  output logic               MemRead,
  output logic               MemWrite,
  output logic [1:0]         ALUOp,
  output logic [31:0]        pc_plus4_out,
  output logic [31:0]        read_data1,
  output logic [31:0]        read_data2,
  output logic [31:0]        sign_ext,
  output logic [4:0]         rs,
  output logic [4:0]         rt,
  output logic [4:0]         rd,
  output logic               idex_flush,
  output logic               pc_write,
  output logic               ifid_write,
  output logic               ifid_flush,
  output logic               branch_taken,
  output logic [31:0]        branch_target,
  output logic [COUNT_W-1:0] stall_count
);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  logic [31:0]        rf_q [32];
  logic [31:0]        rf_d [32];
  logic [COUNT_W-1:0] stall_count_q, stall_count_d;

  logic [5:0] opcode;
  logic       wb_we;
  logic       is_beq;
  logic       uses_rt;
  logic       load_use;
  logic       br_haz;
  logic       stall;

  assign opcode       = instr_in[31:26];
  assign rs           = instr_in[25:21];
  assign rt           = instr_in[20:16];
  assign rd           = instr_in[15:11];
  assign sign_ext     = {{16{instr_in[15]}}, instr_in[15:0]};
  assign pc_plus4_out = pc_plus4_in;
  assign wb_we        = wb_reg_write && (wb_write_reg != 5'd0);

  // Reads see a same-cycle write-back so the decode never uses a stale operand.
  always_comb begin
    read_data1 = rf_q[rs];
    if (rs == 5'd0) read_data1 = 32'd0;
    else if (wb_we && (wb_write_reg == rs)) read_data1 = wb_write_data;
    read_data2 = rf_q[rt];
    if (rt == 5'd0) read_data2 = 32'd0;
    else if (wb_we && (wb_write_reg == rt)) read_data2 = wb_write_data;
  end

  always_comb begin
    rf_d = rf_q;
    if (wb_we) rf_d[wb_write_reg] = wb_write_data;
  end

  always_comb begin
    RegDst   = 1'b0;
    ALUSrc   = 1'b0;
    MemtoReg = 1'b0;
    RegWrite = 1'b0;
    MemRead  = 1'b0;
    MemWrite = 1'b0;
    ALUOp    = 2'b00;
    is_beq   = 1'b0;
    uses_rt  = 1'b0;
    case (opcode)
      OP_RTYPE: begin
        RegDst   = 1'b1;
        RegWrite = 1'b1;
        ALUOp    = 2'b10;
        uses_rt  = 1'b1;
      end
      OP_LW: begin
        ALUSrc   = 1'b1;
        MemtoReg = 1'b1;
        RegWrite = 1'b1;
        MemRead  = 1'b1;
      end
      OP_SW: begin
        ALUSrc   = 1'b1;
        MemWrite = 1'b1;
        uses_rt  = 1'b1;
      end
      OP_BEQ: begin
        ALUOp    = 2'b01;
        is_beq   = 1'b1;
        uses_rt  = 1'b1;
      end
      OP_ADDI: begin
        ALUSrc   = 1'b1;
        RegWrite = 1'b1;
      end
      default: ;
    endcase
  end

  function automatic logic src_match(input logic [4:0] r, input logic [4:0] s,
                                     input logic [4:0] t, input logic use_t);
    return (r != 5'd0) && ((r == s) || ((r == t) && use_t));
  endfunction

  // Control outputs stay ungated on a stall; the ID/EX flush makes the bubble.
  always_comb begin
    load_use = ex_mem_read && src_match(ex_write_reg, rs, rt, uses_rt);
    br_haz   = is_beq &&
               ((ex_reg_write && src_match(ex_write_reg, rs, rt, uses_rt)) ||
                (mem_reg_write && src_match(mem_write_reg, rs, rt, uses_rt)));
    stall        = load_use || br_haz;
    pc_write     = !stall;
    ifid_write   = !stall;
    idex_flush   = stall;
    branch_taken = is_beq && !stall && (read_data1 == read_data2);
    ifid_flush   = branch_taken;
  end

  assign branch_target = pc_plus4_in + {sign_ext[29:0], 2'b00};

  always_comb begin
    stall_count_d = stall_count_q;
    if (stall && !(&stall_count_q)) stall_count_d = stall_count_q + 1'b1;
  end

  assign stall_count = stall_count_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) rf_q[i] <= 32'd0;
      stall_count_q <= '0;
    end else begin
      rf_q          <= rf_d;
      stall_count_q <= stall_count_d;
    end
  end

endmodule

// File: tb/tb_id_stage.sv
// Directed bench for id_stage: decode, bypass, hazards, early beq and the
// saturating stall counter (instantiated with a 2-bit counter).
module tb_id_stage;

  logic        clk;
  logic        rst;
  logic [31:0] instr_in;
  logic [31:0] pc_plus4_in;
  logic        wb_reg_write;
  logic [4:0]  wb_write_reg;
  logic [31:0] wb_write_data;
  logic        ex_mem_read;
  logic        ex_reg_write;
  logic [4:0]  ex_write_reg;
  logic        mem_reg_write;
  logic [4:0]  mem_write_reg;
  logic        RegDst, ALUSrc, MemtoReg, RegWrite, MemRead, MemWrite;
  logic [1:0]  ALUOp;
  logic [31:0] pc_plus4_out, read_data1, read_data2, sign_ext, branch_target;
  logic [4:0]  rs, rt, rd;
  logic        idex_flush, pc_write, ifid_write, ifid_flush, branch_taken;
  logic [1:0]  stall_count;

  int checks;
  int failures;

  id_stage #(.COUNT_W(2)) dut (
    .clk(clk), .rst(rst), .instr_in(instr_in), .pc_plus4_in(pc_plus4_in),
    .wb_reg_write(wb_reg_write), .wb_write_reg(wb_write_reg),
    .wb_write_data(wb_write_data), .ex_mem_read(ex_mem_read),
    .ex_reg_write(ex_reg_write), .ex_write_reg(ex_write_reg),
    .mem_reg_write(mem_reg_write), .mem_write_reg(mem_write_reg),
    .RegDst(RegDst), .ALUSrc(ALUSrc), .MemtoReg(MemtoReg), .RegWrite(RegWrite),
    .MemRead(MemRead), .MemWrite(MemWrite), .ALUOp(ALUOp),
    .pc_plus4_out(pc_plus4_out), .read_data1(read_data1), .read_data2(read_data2),
    .sign_ext(sign_ext), .rs(rs), .rt(rt), .rd(rd), .idex_flush(idex_flush),
    .pc_write(pc_write), .ifid_write(ifid_write), .ifid_flush(ifid_flush),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .stall_count(stall_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] ctrl();
    return {RegDst, ALUSrc, MemtoReg, RegWrite, MemRead, MemWrite, ALUOp};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Inputs change just after a falling edge; outputs are sampled 1ns later.
  task automatic next_cycle();
    @(negedge clk);
  endtask

  task automatic wb(input logic en, input logic [4:0] r, input logic [31:0] d);
    wb_reg_write  = en;
    wb_write_reg  = r;
    wb_write_data = d;
  endtask

  initial begin
    logic [1:0] sat_exp [5];
    checks = 0;
    failures = 0;
    rst = 1'b1;
    instr_in = 32'h0109_5020;
    pc_plus4_in = 32'h40;
    wb(1'b0, 5'd0, 32'd0);
    ex_mem_read = 1'b0; ex_reg_write = 1'b0; ex_write_reg = 5'd0;
    mem_reg_write = 1'b0; mem_write_reg = 5'd0;
    #1;
    chk("reset_count", 32'(stall_count), 32'd0);
    chk("reset_rd1", read_data1, 32'd0);
    chk("reset_rd2", read_data2, 32'd0);
    next_cycle();
    rst = 1'b0;

    wb(1'b1, 5'd8, 32'h1234);
    next_cycle();
    wb(1'b0, 5'd0, 32'd0);
    #1;
    chk("add_rd1", read_data1, 32'h1234);
    chk("add_rd2", read_data2, 32'd0);
    chk("add_ctrl", 32'(ctrl()), 32'h92);
    chk("add_rs", 32'(rs), 32'd8);
    chk("add_rt", 32'(rt), 32'd9);
    chk("add_rd", 32'(rd), 32'd10);
    chk("add_sext", sign_ext, 32'h5020);
    chk("add_pc_pass", pc_plus4_out, 32'h40);
    chk("add_no_stall", {29'd0, idex_flush, pc_write, ifid_write}, 32'b011);

    next_cycle();
    wb(1'b1, 5'd9, 32'hCAFE);
    #1 chk("bypass_rd2", read_data2, 32'hCAFE);
    next_cycle();
    instr_in = 32'h0009_5020;
    wb(1'b1, 5'd0, 32'hFFFF);
    #1 chk("r0_bypass_rd1", read_data1, 32'd0);
    chk("stored_rd2", read_data2, 32'hCAFE);
    next_cycle();
    wb(1'b0, 5'd0, 32'd0);
    #1 chk("r0_after_write", read_data1, 32'd0);

    next_cycle();
    instr_in = 32'h0109_5020;
    ex_mem_read = 1'b1; ex_write_reg = 5'd8;
    #1 chk("lu_rs_stall", {29'd0, idex_flush, pc_write, ifid_write}, 32'b100);
    chk("lu_ifid_flush", {31'd0, ifid_flush}, 32'd0);
    chk("lu_ctrl_ungated", 32'(ctrl()), 32'h92);
    next_cycle();
    ex_write_reg = 5'd0;
    #1 chk("lu_count1", 32'(stall_count), 32'd1);
    chk("lu_r0_no_stall", {29'd0, idex_flush, pc_write, ifid_write}, 32'b011);
    next_cycle();
    ex_write_reg = 5'd9;
    #1 chk("lu_hold_count", 32'(stall_count), 32'd1);
    chk("lu_rt_stall", {31'd0, idex_flush}, 32'd1);

    next_cycle();
    instr_in = 32'h8C23_0000;
    ex_write_reg = 5'd3;
    #1 chk("lw_count2", 32'(stall_count), 32'd2);
    chk("lw_ctrl", 32'(ctrl()), 32'h78);
    chk("lw_rt_no_stall", {31'd0, idex_flush}, 32'd0);
    next_cycle();
    instr_in = 32'hAC23_0000;
    #1 chk("sw_ctrl", 32'(ctrl()), 32'h44);
    chk("sw_rt_stall", {31'd0, idex_flush}, 32'd1);
    next_cycle();
    ex_mem_read = 1'b0; ex_write_reg = 5'd0;
    instr_in = 32'h2023_0004;
    #1 chk("addi_ctrl", 32'(ctrl()), 32'h50);
    chk("addi_sext", sign_ext, 32'd4);
    chk("count_sat3", 32'(stall_count), 32'd3);

    next_cycle();
    instr_in = 32'hFC00_0000;
    wb(1'b1, 5'd1, 32'd5);
    #1 chk("nop_ctrl", 32'(ctrl()), 32'h00);
    next_cycle();
    wb(1'b1, 5'd2, 32'd5);
    next_cycle();
    wb(1'b0, 5'd0, 32'd0);
    instr_in = 32'h1022_0003;
    pc_plus4_in = 32'h100;
    #1 chk("beq_ctrl", 32'(ctrl()), 32'h01);
    chk("beq_taken", {30'd0, branch_taken, ifid_flush}, 32'b11);
    chk("beq_target", branch_target, 32'h10C);
    chk("beq_no_flush", {31'd0, idex_flush}, 32'd0);
    next_cycle();
    wb(1'b1, 5'd2, 32'd6);
    #1 chk("beq_ne_bypass", {30'd0, branch_taken, ifid_flush}, 32'b00);
    next_cycle();
    instr_in = 32'h1022_FFFF;
    ex_reg_write = 1'b1; ex_write_reg = 5'd1;
    wb(1'b1, 5'd2, 32'd5);
    #1 chk("beq_neg_target", branch_target, 32'hFC);
    chk("beq_ex_haz", {29'd0, idex_flush, pc_write, branch_taken}, 32'b100);
    next_cycle();
    wb(1'b0, 5'd0, 32'd0);
    ex_reg_write = 1'b0; ex_write_reg = 5'd0;
    instr_in = 32'h1022_0003;
    #1 chk("beq_resolved", {30'd0, branch_taken, pc_write}, 32'b11);
    next_cycle();
    mem_reg_write = 1'b1; mem_write_reg = 5'd2;
    #1 chk("beq_mem_haz", {30'd0, idex_flush, branch_taken}, 32'b10);
    next_cycle();
    instr_in = 32'h0109_5020;
    mem_write_reg = 5'd8;
    #1 chk("add_mem_no_stall", {31'd0, idex_flush}, 32'd0);
    next_cycle();
    mem_reg_write = 1'b0; mem_write_reg = 5'd0;

    #2 rst = 1'b1;
    #1 chk("async_rst_count", 32'(stall_count), 32'd0);
    chk("async_rst_rf", read_data1, 32'd0);
    next_cycle();
    rst = 1'b0;
    ex_mem_read = 1'b1; ex_write_reg = 5'd8;
    sat_exp[0] = 2'd1; sat_exp[1] = 2'd2; sat_exp[2] = 2'd3;
    sat_exp[3] = 2'd3; sat_exp[4] = 2'd3;
    for (int k = 0; k < 5; k++) begin
      next_cycle();
      #1 chk($sformatf("sat_step%0d", k), 32'(stall_count), 32'(sat_exp[k]));
    end
    #2 rst = 1'b1;
    #1 chk("mid_rst_count", 32'(stall_count), 32'd0);
    rst = 1'b0;
    ex_mem_read = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
